// File: rtl/l1_mem_arbiter_if.sv
// generic_bus_if: simple request/response memory bus shared by the L1 caches
// and the memory/bus controller.
//
// Handshake: a requester holds ren or wen (with addr/wdata/byte_en stable)
// until it samples busy=0; the cycle with busy=0 carries rdata for reads and
// marks the write as accepted.
//
//   master modport : addr, wdata, ren, wen, byte_en out; rdata, busy in
//   slave  modport : addr, wdata, ren, wen, byte_en in;  rdata, busy out
interface generic_bus_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   wdata;
  logic [ADDR_W-1:0]   rdata;
  logic                ren;
  logic                wen;
  logic                busy;
  logic [ADDR_W/8-1:0] byte_en;

  modport master (output addr, wdata, ren, wen, byte_en, input rdata, busy);
  modport slave  (input addr, wdata, ren, wen, byte_en, output rdata, busy);
endinterface

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one memory-side generic_bus_if between the D-cache
// (requester 0) and the I-cache (requester 1).
//
// Ports:
//   CLK            system clock
//   nRST           synchronous active-low reset
//   dcache_bus_if  slave  - requester 0 (D-cache)
//   icache_bus_if  slave  - requester 1 (I-cache)
//   mem_bus_if     master - shared memory bus
//   state_o        debug view of the arbiter FSM state
//
// Optional build macro: L1_ARB_ROUND_ROBIN_EN
//   defined   - ties go to the requester that is not last_owner
//   undefined - ties go to the D-cache
//
// One owner is granted at a time and keeps the bus for the whole
// transaction. Every completion returns to IDLE for one bubble cycle, during
// which the owner may present its next address and is re-granted (sticky)
// while its burst count is below BURST_LIMIT.
module l1_mem_arbiter #(
  parameter int BURST_LIMIT = 4,
  parameter int ADDR_W      = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  generic_bus_if.slave  dcache_bus_if,
  generic_bus_if.slave  icache_bus_if,
  generic_bus_if.master mem_bus_if,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_D = 2'd1,
    GNT_I = 2'd2
  } state_t;

  localparam logic [3:0] BL    = 4'(BURST_LIMIT);
  localparam logic       OWN_D = 1'b0;
  localparam logic       OWN_I = 1'b1;

  state_t     state_q, state_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic       last_owner_q, last_owner_d;

  logic req_d, req_i;
  logic win_i;
  logic granted, own_i;

  assign req_d = dcache_bus_if.ren | dcache_bus_if.wen;
  assign req_i = icache_bus_if.ren | icache_bus_if.wen;

  // Arbitration. Sticky only applies inside an active burst (count > 0),
  // so after an idle period the tie-break decides again.
  always_comb begin
    win_i = OWN_D;
    if (req_i && !req_d) begin
      win_i = OWN_I;
    end else if (req_d && req_i) begin
      if (beat_cnt_q != 4'd0 && beat_cnt_q < BL) begin
        win_i = last_owner_q;
      end else begin
`ifdef L1_ARB_ROUND_ROBIN_EN
        win_i = ~last_owner_q;
`else
        // D-cache wins ties unless it is the owner that just hit the cap.
        win_i = (last_owner_q == OWN_D) && (beat_cnt_q >= BL);
`endif
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req_d || req_i) begin
          state_d      = win_i ? GNT_I : GNT_D;
          last_owner_d = win_i;
          // A new owner starts its burst count from scratch.
          if (win_i != last_owner_q) beat_cnt_d = 4'd0;
        end else begin
          beat_cnt_d = 4'd0;
        end
      end
      GNT_D, GNT_I: begin
        if (!(own_i ? req_i : req_d)) begin
          state_d = IDLE;  // abandoned: no completion counted
        end else if (!mem_bus_if.busy) begin
          state_d    = IDLE;
          beat_cnt_d = (beat_cnt_q < BL) ? beat_cnt_q + 4'd1 : BL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      beat_cnt_q   <= 4'd0;
      last_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Memory-side outputs depend only on registered state and requester
  // inputs, never on mem busy.
  assign granted = (state_q == GNT_D) || (state_q == GNT_I);
  assign own_i   = (state_q == GNT_I);
  assign state_o = state_q;

  assign mem_bus_if.addr    = !granted ? '0 : own_i ? icache_bus_if.addr    : dcache_bus_if.addr;
  assign mem_bus_if.wdata   = !granted ? '0 : own_i ? icache_bus_if.wdata   : dcache_bus_if.wdata;
  assign mem_bus_if.byte_en = !granted ? '0 : own_i ? icache_bus_if.byte_en : dcache_bus_if.byte_en;
  // Write wins when a requester raises both strobes.
  assign mem_bus_if.wen = granted && (own_i ? icache_bus_if.wen : dcache_bus_if.wen);
  assign mem_bus_if.ren = granted && (own_i ? (icache_bus_if.ren && !icache_bus_if.wen)
                                            : (dcache_bus_if.ren && !dcache_bus_if.wen));

  assign dcache_bus_if.busy  = (state_q == GNT_D) ? mem_bus_if.busy  : 1'b1;
  assign dcache_bus_if.rdata = (state_q == GNT_D) ? mem_bus_if.rdata : '0;
  assign icache_bus_if.busy  = (state_q == GNT_I) ? mem_bus_if.busy  : 1'b1;
  assign icache_bus_if.rdata = (state_q == GNT_I) ? mem_bus_if.rdata : '0;

endmodule
